// File: rtl/screen_mem_arbiter.sv
// Shares one SDRAM controller port between posted CPU screen writes and VGA word reads.
// At most one controller transaction is outstanding at a time, and every transaction returns through IDLE.
module screen_mem_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_data,
  output logic        cpu_full,
  input  logic        vga_req,
  input  logic [12:0] vga_addr,
  output logic [15:0] vga_data,
  output logic        vga_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_d,
  input  logic        mem_ready,
  input  logic [15:0] mem_q,
  input  logic        mem_q_valid,
  output logic [2:0]  err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t        state;
  logic [30:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pending;
  logic [12:0]   rd_addr;
  logic [TW-1:0] rd_cnt;

  logic          in_screen;
  logic          full;
  logic          push_req;
  logic          push;
  logic          accept;
  logic          pop;
  logic          in_flight;
  logic [30:0]   head;

  // Screen memory is 0x4000..0x5FFF: top two address bits are 2'b10.
  assign in_screen = (cpu_addr[14:13] == 2'b10);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push_req  = cpu_we && in_screen;
  assign push      = push_req && !full;
  assign accept    = mem_req && mem_ready;
  assign pop       = (state == WR_REQ) && accept;
  assign in_flight = (state == RD_REQ) || (state == RD_WAIT);
  assign head      = fifo_mem[rd_ptr];
  assign cpu_full  = full;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cpu_addr, cpu_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= 1'b0;
      rd_addr   <= '0;
      rd_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_d     <= '0;
      vga_data  <= '0;
      vga_valid <= 1'b0;
      err       <= '0;
    end else begin
      vga_valid <= 1'b0;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) err[0] <= 1'b1;
      if (vga_req) begin
        if (pending || in_flight) begin
          err[1] <= 1'b1;
        end else begin
          pending <= 1'b1;
          rd_addr <= vga_addr;
        end
      end

      case (state)
        IDLE: begin
          // A full FIFO outranks a waiting read so the CPU is never stalled indefinitely.
          if (full || (!pending && count != '0)) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= head[30:16];
            mem_d    <= head[15:0];
            state    <= WR_REQ;
          end else if (pending) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {2'b10, rd_addr};
            state    <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (accept) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_REQ: begin
          if (accept) begin
            mem_req <= 1'b0;
            pending <= 1'b0;
            rd_cnt  <= '0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_q_valid) begin
            vga_data  <= mem_q;
            vga_valid <= 1'b1;
            state     <= IDLE;
          end else if (rd_cnt == TW'(RD_TIMEOUT)) begin
            err[2]    <= 1'b1;
            vga_data  <= '0;
            vga_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed bench for screen_mem_arbiter: a depth-4 instance for most scenarios and a depth-1
// instance where a full FIFO and a pending read can meet in IDLE.
module tb_screen_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        vga_req;
  logic [12:0] vga_addr;
  logic        mem_ready;
  logic [15:0] mem_q;
  logic        mem_q_valid;

  logic        cpu_full, vga_valid, mem_req, mem_we;
  logic [15:0] vga_data, mem_d;
  logic [14:0] mem_addr;
  logic [2:0]  err;

  logic        cpu_full_1, vga_valid_1, mem_req_1, mem_we_1;
  logic [15:0] vga_data_1, mem_d_1;
  logic [14:0] mem_addr_1;
  logic [2:0]  err_1;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];

  always #5 clk = ~clk;

  screen_mem_arbiter #(.FIFO_DEPTH(4), .RD_TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_full(cpu_full), .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
    .vga_valid(vga_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_ready(mem_ready), .mem_q(mem_q), .mem_q_valid(mem_q_valid), .err(err)
  );

  screen_mem_arbiter #(.FIFO_DEPTH(1), .RD_TIMEOUT(255)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_full(cpu_full_1), .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data_1),
    .vga_valid(vga_valid_1), .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_d(mem_d_1), .mem_ready(mem_ready), .mem_q(mem_q), .mem_q_valid(mem_q_valid), .err(err_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    tick();
    cpu_we   = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; cpu_we = 0; cpu_addr = 0; cpu_data = 0; vga_req = 0; vga_addr = 0;
    mem_ready = 0; mem_q = 0; mem_q_valid = 0;
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_vga_data", vga_data, 0);
    check("rst_vga_valid", vga_valid, 0);
    check("rst_cpu_full", cpu_full, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // Single write: request visible in the cycle after IDLE picks it up, accepted at edge 2.
    mem_ready = 1'b1;
    cpu_write(15'd16384, 16'hBEEF);
    check("wr1_req_early", mem_req, 0);
    tick();
    check("wr1_req", mem_req, 1);
    check("wr1_we", mem_we, 1);
    check("wr1_addr", mem_addr, 16384);
    check("wr1_data", mem_d, 16'hBEEF);
    tick();
    check("wr1_req_drop", mem_req, 0);
    tick();
    check("wr1_empty", mem_req, 0);
    check("wr1_full", cpu_full, 0);

    // Address filter and overflow with the controller stalled.
    do_reset();
    mem_ready = 1'b0;
    cpu_write(15'd100, 16'h1111);
    cpu_write(15'd24576, 16'h2222);
    check("filt_no_req", mem_req, 0);
    check("filt_full", cpu_full, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_write(15'(16400 + i), 16'hA000 + 16'(i));
      exp_q.push_back({15'(16400 + i), 16'hA000 + 16'(i)});
    end
    check("ovf_full", cpu_full, 1);
    check("ovf_err_before", err, 3'b000);
    cpu_write(15'd16404, 16'hA004);
    check("ovf_err", err, 3'b001);
    check("ovf_held_req", mem_req, 1);
    check("ovf_held_addr", mem_addr, 16400);
    mem_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      if (mem_req) begin
        check("ovf_order_we", mem_we, 1);
        check("ovf_order", {mem_addr, mem_d}, exp_q.pop_front());
      end
      tick();
      n++;
    end
    check("ovf_all_issued", exp_q.size(), 0);
    check("ovf_drained", cpu_full, 0);
    tick();
    check("ovf_no_fifth", mem_req, 0);

    // Read path: data returned three cycles after acceptance.
    do_reset();
    mem_ready = 1'b1;
    vga_req = 1'b1; vga_addr = 13'd5;
    tick();
    vga_req = 1'b0;
    tick();
    check("rd_req", mem_req, 1);
    check("rd_we", mem_we, 0);
    check("rd_addr", mem_addr, 16389);
    tick();
    check("rd_req_drop", mem_req, 0);
    tick();
    tick();
    check("rd_no_valid_yet", vga_valid, 0);
    mem_q_valid = 1'b1; mem_q = 16'h1234;
    tick();
    mem_q_valid = 1'b0; mem_q = 16'h0;
    check("rd_valid", vga_valid, 1);
    check("rd_data", vga_data, 16'h1234);
    tick();
    check("rd_valid_pulse", vga_valid, 0);
    check("rd_data_hold", vga_data, 16'h1234);

    // Priority: one entry plus pending read -> read first (depth 4); full plus pending -> write first (depth 1).
    do_reset();
    mem_ready = 1'b1;
    cpu_we = 1'b1; cpu_addr = 15'd16500; cpu_data = 16'h0A0A;
    vga_req = 1'b1; vga_addr = 13'h1FFF;
    tick();
    cpu_we = 1'b0; vga_req = 1'b0;
    check("pri_full_d1", cpu_full_1, 1);
    check("pri_full_d4", cpu_full, 0);
    tick();
    check("pri_rd_req", mem_req, 1);
    check("pri_rd_we", mem_we, 0);
    check("pri_rd_addr_top", mem_addr, 24575);
    check("pri_d1_req", mem_req_1, 1);
    check("pri_d1_we", mem_we_1, 1);
    check("pri_d1_addr", mem_addr_1, 16500);
    tick();
    mem_q_valid = 1'b1; mem_q = 16'h5555;
    tick();
    mem_q_valid = 1'b0; mem_q = 16'h0;
    check("pri_rd_valid", vga_valid, 1);
    check("pri_rd_data", vga_data, 16'h5555);
    tick();
    check("pri_wr_req", mem_req, 1);
    check("pri_wr_we", mem_we, 1);
    check("pri_wr_addr", mem_addr, 16500);
    check("pri_wr_data", mem_d, 16'h0A0A);

    // Dropped second read during RD_WAIT, then timeout.
    do_reset();
    check("to_err_clear", err, 0);
    mem_ready = 1'b1;
    vga_req = 1'b1; vga_addr = 13'd9;
    tick();
    vga_req = 1'b0;
    tick();
    tick();
    vga_req = 1'b1; vga_addr = 13'd10;
    tick();
    vga_req = 1'b0;
    check("drop_err", err, 3'b010);
    n = 1;
    while (!vga_valid && n < 400) begin
      tick();
      n++;
    end
    check("to_valid", vga_valid, 1);
    check("to_window", (n >= 250 && n <= 260), 1);
    check("to_data", vga_data, 0);
    check("to_err", err, 3'b110);
    tick();
    check("to_no_reissue", mem_req, 0);

    // Reset during WR_REQ.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(15'(16384 + i), 16'(i));
    check("rst_wr_pre_req", mem_req, 1);
    check("rst_wr_pre_err", err, 3'b001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_wr_req", mem_req, 0);
    check("rst_wr_err", err, 0);
    check("rst_wr_full", cpu_full, 0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_wr_empty", mem_req, 0);
    end

    // Reset while a read is in flight: its late data must be ignored.
    vga_req = 1'b1; vga_addr = 13'd3;
    tick();
    vga_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_q_valid = 1'b1; mem_q = 16'hFFFF;
    tick();
    mem_q_valid = 1'b0;
    check("late_q_valid", vga_valid, 0);
    check("late_q_data", vga_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
